// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MemoryAccess stage: byte-enable single-port BRAM with
// valid/ready request/response, sign/zero-extended loads and two-beat misaligned accesses.
module dmem_ctrl #(
    parameter  int AWIDTH    = 10,
    parameter  int NB_COL    = 4,
    parameter  int COL_WIDTH = 8,
    localparam int LB        = $clog2(NB_COL),
    localparam int DW        = NB_COL * COL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [AWIDTH+LB-1:0] req_addr,
    input  logic [DW-1:0]        req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err
);
    typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_t;

    // off+n can reach 2*NB_COL-1 (or beyond for an illegal size), hence LB+2 bits.
    localparam logic [LB+1:0] ONE      = (LB+2)'(1);
    localparam logic [LB+1:0] NB_COL_W = (LB+2)'(NB_COL);

    state_t state, state_nxt;

    logic              accept;
    logic [LB-1:0]     req_off;
    logic [AWIDTH-1:0] req_word;
    logic [LB+1:0]     req_nbytes, req_end;
    logic              req_err, req_split;
    logic [DW-1:0]     req_rot;
    logic [NB_COL-1:0] be1, be2;

    logic              r_we, r_uns, r_err, r_split;
    logic [LB-1:0]     r_off;
    logic [AWIDTH-1:0] r_word;
    logic [LB+1:0]     r_end, r_nbytes;
    logic [DW-1:0]     r_rot, hold;

    logic              ram_en;
    logic [AWIDTH-1:0] ram_addr;
    logic [NB_COL-1:0] ram_be;
    logic [DW-1:0]     ram_din, ram_dout;
    logic [DW-1:0]     mem [2**AWIDTH];

    logic [DW-1:0]     merged, ext;
    logic              sign;

    assign req_off    = req_addr[LB-1:0];
    assign req_word   = req_addr[AWIDTH+LB-1:LB];
    assign req_nbytes = ONE << req_size;
    assign req_end    = {2'b00, req_off} + req_nbytes;
    assign req_err    = req_nbytes > NB_COL_W;
    assign req_split  = req_end > NB_COL_W;
    assign req_rot    = (req_wdata << (int'(req_off) * COL_WIDTH))
                      | (req_wdata >> ((NB_COL - int'(req_off)) * COL_WIDTH));

    always_comb begin
        for (int i = 0; i < NB_COL; i++) begin
            be1[i] = (i >= int'(req_off)) && (i < int'(req_end));
            be2[i] = (i + NB_COL) < int'(r_end);
        end
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_en    = 1'b0;
        ram_addr  = req_word;
        ram_be    = '0;
        ram_din   = req_rot;
        case (state)
            IDLE:  req_ready = 1'b1;
            SPLIT: begin
                ram_en    = 1'b1;
                ram_addr  = r_word + AWIDTH'(1);
                ram_be    = r_we ? be2 : '0;
                ram_din   = r_rot;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = req_valid && req_ready;
        if (accept) begin
            state_nxt = (req_split && !req_err) ? SPLIT : RESP;
            ram_en    = !req_err;
            ram_addr  = req_word;
            ram_be    = req_we ? be1 : '0;
            ram_din   = req_rot;
        end
        // A reset landing in SPLIT must drop beat 2 rather than write it.
        if (rst) ram_en = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r_we  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_we  <= req_we;
                r_err <= req_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            r_uns    <= req_unsigned;
            r_split  <= req_split;
            r_off    <= req_off;
            r_word   <= req_word;
            r_end    <= req_end;
            r_nbytes <= req_nbytes;
            r_rot    <= req_rot;
        end
        if (state == SPLIT) hold <= ram_dout >> (int'(r_off) * COL_WIDTH);
    end

    // NOTE: RAM contents and its read register are deliberately not reset so they map onto BRAM.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < NB_COL; i++)
                if (ram_be[i]) mem[ram_addr][i*COL_WIDTH +: COL_WIDTH] <= ram_din[i*COL_WIDTH +: COL_WIDTH];
            ram_dout <= mem[ram_addr];
        end
    end

    always_comb begin
        merged = r_split ? (hold | (ram_dout << ((NB_COL - int'(r_off)) * COL_WIDTH)))
                         : (ram_dout >> (int'(r_off) * COL_WIDTH));
        sign = 1'b0;
        for (int i = 0; i < NB_COL; i++)
            if (i < int'(r_nbytes)) sign = merged[i*COL_WIDTH + COL_WIDTH - 1];
        sign = sign && !r_uns;
        ext = '0;
        for (int i = 0; i < NB_COL; i++)
            ext[i*COL_WIDTH +: COL_WIDTH] = (i < int'(r_nbytes)) ? merged[i*COL_WIDTH +: COL_WIDTH]
                                                                  : {COL_WIDTH{sign}};
    end

    assign rsp_rdata = (state == RESP && !r_we && !r_err) ? ext : '0;
    assign rsp_err   = (state == RESP) && r_err;

endmodule
